// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings, default latencies and op helpers for the MIPS multiply/divide unit
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // True for the four operations that occupy the unit for several cycles
    function automatic logic is_md_start_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU on latched operands
import mdu_pkg::*;

module mdu_calc (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  md_op_e      op_i,
    output logic [63:0] result_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;
    logic [31:0] udiv_q;
    logic [31:0] udiv_r;
    logic        b_zero;
    logic        div_ovf;

    assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend
    assign mag_a  = a_i[31] ? (~a_i + 32'd1) : a_i;
    assign mag_b  = b_i[31] ? (~b_i + 32'd1) : b_i;
    assign mag_q  = mag_a / mag_b;
    assign mag_r  = mag_a % mag_b;
    assign sdiv_q = (a_i[31] ^ b_i[31]) ? (~mag_q + 32'd1) : mag_q;
    assign sdiv_r = a_i[31] ? (~mag_r + 32'd1) : mag_r;

    assign udiv_q = a_i / b_i;
    assign udiv_r = a_i % b_i;

    assign b_zero  = (b_i == 32'd0);
    assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    // Select the result; divide-by-zero gives lo=all ones, hi=dividend for both signed and unsigned
    always_comb begin
        result_o = 64'd0;
        case (op_i)
            MD_MULT:  result_o = prod_s;
            MD_MULTU: result_o = prod_u;
            MD_DIV: begin
                if (b_zero)       result_o = {a_i, 32'hFFFF_FFFF};
                else if (div_ovf) result_o = {32'd0, 32'h8000_0000};
                else              result_o = {sdiv_r, sdiv_q};
            end
            MD_DIVU: begin
                if (b_zero) result_o = {a_i, 32'hFFFF_FFFF};
                else        result_o = {udiv_r, udiv_q};
            end
            default:  result_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle MD sequencer with HI/LO; MDU_DIV_ZERO_SKIP_EN makes divide-by-zero a no-op
import mdu_pkg::*;

module mdu_sequencer #(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    md_op_e             op_q, op_d;
    logic [63:0]        calc_result;
    logic               launch;

    mdu_calc u_calc (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (calc_result)
    );

    // Decide whether this cycle's start begins a multi-cycle operation
`ifdef MDU_DIV_ZERO_SKIP_EN
    assign launch = start && is_md_start_op(md_op) && !(is_div_op(md_op) && (srcb == 32'd0));
`else
    assign launch = start && is_md_start_op(md_op);
`endif

    // Next-state: operand latch and counter load on launch, countdown and HI/LO commit in RUN
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    a_d     = srca;
                    b_d     = srcb;
                    op_d    = md_op_e'(md_op);
                    count_d = is_div_op(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else if (md_op == MD_MTHI) begin
                    hi_d = srca;
                end else if (md_op == MD_MTLO) begin
                    lo_d = srca;
                end
            end
            ST_RUN: begin
                if (count_q == CNT_W'(1)) begin
                    hi_d    = calc_result[63:32];
                    lo_d    = calc_result[31:0];
                    count_d = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                count_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register update; reset aborts any operation without touching HI/LO afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= MD_NONE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic        start;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_pass;

    mdu_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md_op (md_op),
        .start (start),
        .srca  (srca),
        .srcb  (srcb),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stall logic guarantees no start while busy
    always @(posedge clk) begin
        if (!reset && busy && start)
            $error("protocol: start asserted while busy");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns in cycle T+1
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        md_op = 4'd0;
    endtask

    // Count busy cycles from the current one, bounded
    task automatic wait_done(input string tag, input int already, input int exp_lat);
        int cnt;
        cnt = already;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            step();
        end
        check({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b);
        wait_done(tag, 0, lat);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        md_op = 4'd0;
        start = 1'b0;
        srca  = 32'd0;
        srcb  = 32'd0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divovf",4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("divu",  4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // MTHI in IDLE: visible next cycle, no busy
        md_op = 4'd5;
        srca  = 32'h0000_1234;
        step();
        md_op = 4'd0;
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo", lo, 32'd14);
        check("mthi_busy", {31'd0, busy}, 32'd0);

        // MTLO and operand changes during RUN have no effect
        issue(4'd1, 32'd7, 32'd6);
        md_op = 4'd6;
        srca  = 32'hDEAD_BEEF;
        srcb  = 32'h0000_0099;
        step();
        md_op = 4'd0;
        check("run_mtlo_lo", lo, 32'd14);
        check("run_hi_stable", hi, 32'h0000_1234);
        wait_done("mult76", 1, 5);
        check("mult76_hi", hi, 32'd0);
        check("mult76_lo", lo, 32'd42);

        run_op("divneg", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

`ifdef MDU_DIV_ZERO_SKIP_EN
        issue(4'd3, 32'd5, 32'd0);
        for (int i = 0; i < 12; i++) begin
            check("div0_busy", {31'd0, busy}, 32'd0);
            step();
        end
        check("div0_hi", hi, 32'd1);
        check("div0_lo", lo, 32'hFFFF_FFFD);
`else
        run_op("div0", 4'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
        run_op("divu0", 4'd4, 32'd9, 32'd0, 10, 32'd9, 32'hFFFF_FFFF);
`endif

        // Reset in the third busy cycle of a DIV aborts it
        run_op("pre_rst", 4'd4, 32'd50, 32'd3, 10, 32'd2, 32'd16);
        issue(4'd3, 32'd100, 32'd3);
        step();
        step();
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("rst_nocommit_busy", {31'd0, busy}, 32'd0);
        check("rst_nocommit_hi", hi, 32'd0);
        check("rst_nocommit_lo", lo, 32'd0);

        run_op("mult_min", 4'd1, 32'h8000_0000, 32'd2, 5, 32'hFFFF_FFFF, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
